// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : regfile_write_arbiter
// Two-requester round-robin write port arbiter for a register file, with a
// single issue register and read-bypass match flags.
// Rev    : 1.0
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              req0,
  input  logic [ADDR_W-1:0] wrAddr0,
  input  logic [DATA_W-1:0] wrData0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] wrAddr1,
  input  logic [DATA_W-1:0] wrData1,
  output logic              gnt1,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic              fwdA,
  output logic              fwdB
);

  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_t;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  last_t             last_q, last_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              grant0, grant1;

  // Contention goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!stall) begin
      if (req0 && req1) begin
        grant0 = (last_q == LAST_REQ1);
        grant1 = (last_q == LAST_REQ0);
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  // Writes to the zero register are accepted but never issued; the issue
  // register then keeps its previous address/data.
  always_comb begin
    last_d    = last_q;
    write_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant0) begin
      last_d = LAST_REQ0;
      if (wrAddr0 != ZERO_ADDR) begin
        write_d   = 1'b1;
        wr_addr_d = wrAddr0;
        wr_data_d = wrData0;
      end
    end else if (grant1) begin
      last_d = LAST_REQ1;
      if (wrAddr1 != ZERO_ADDR) begin
        write_d   = 1'b1;
        wr_addr_d = wrAddr1;
        wr_data_d = wrData1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= LAST_REQ1;
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      last_q    <= last_d;
      write_q   <= write_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Grants are masked directly by reset so they drop the instant rst_n falls.
  assign gnt0   = grant0 & rst_n;
  assign gnt1   = grant1 & rst_n;
  assign write  = write_q;
  assign wrAddr = wr_addr_q;
  assign wrData = wr_data_q;
  assign fwdA   = write_q & (wr_addr_q == rdAddrA);
  assign fwdB   = write_q & (wr_addr_q == rdAddrB);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// Testbench for regfile_write_arbiter: directed vector table, corner-case
// sequences, and random traffic against a transaction-level reference model.
module tb_regfile_write_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int ZR = 31;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] wrAddr0 = '0, wrAddr1 = '0, rdAddrA = '0, rdAddrB = '0;
  logic [DW-1:0] wrData0 = '0, wrData1 = '0;
  logic          gnt0, gnt1, write, fwdA, fwdB;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req0(req0), .wrAddr0(wrAddr0), .wrData0(wrData0), .gnt0(gnt0),
    .req1(req1), .wrAddr1(wrAddr1), .wrData1(wrData1), .gnt1(gnt1),
    .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .fwdA(fwdA), .fwdB(fwdB)
  );

  typedef struct {
    logic          stall, r0, r1;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [AW-1:0] ra, rb;
    logic          eg0, eg1, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          efa, efb;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, input logic r0, input logic r1,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic eg0, input logic eg1, input logic ew,
                         input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                         input logic efa, input logic efb);
    vec_t v;
    v.stall = s; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.ra = ra; v.rb = rb; v.eg0 = eg0; v.eg1 = eg1; v.ew = ew; v.ea = ea; v.ed = ed;
    v.efa = efa; v.efb = efb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic eg0, input logic eg1, input logic ew,
                           input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                           input logic efa, input logic efb);
    check({tag, " gnt0"},   DW'(gnt0),   DW'(eg0));
    check({tag, " gnt1"},   DW'(gnt1),   DW'(eg1));
    check({tag, " write"},  DW'(write),  DW'(ew));
    check({tag, " wrAddr"}, DW'(wrAddr), DW'(ea));
    check({tag, " wrData"}, wrData,      ed);
    check({tag, " fwdA"},   DW'(fwdA),   DW'(efa));
    check({tag, " fwdB"},   DW'(fwdB),   DW'(efb));
  endtask

  task automatic set_in(input logic s, input logic r0, input logic r1,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    stall = s; req0 = r0; req1 = r1; wrAddr0 = a0; wrData0 = d0;
    wrAddr1 = a1; wrData1 = d1; rdAddrA = ra; rdAddrB = rb;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: the committed write seen at the output, plus who won last.
  int            m_last;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  initial begin
    // Reset state, with a request present that must not be granted
    req0 = 1'b1; wrAddr0 = 5'd3;
    #2;
    check_all("reset", 0, 0, 0, 5'd0, 64'd0, 0, 0);
    req0 = 1'b0; wrAddr0 = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // stall r0 r1 a0 d0 a1 d1 ra rb | g0 g1 w addr data fA fB
    add_vec(0,1,0, 5'd3,64'd7,     5'd0,64'd0,     5'd3,5'd0, 1,0,0, 5'd0,64'd0,     0,0);
    add_vec(0,0,0, 5'd0,64'd0,     5'd0,64'd0,     5'd3,5'd4, 0,0,1, 5'd3,64'd7,     1,0);
    add_vec(0,0,0, 5'd0,64'd0,     5'd0,64'd0,     5'd3,5'd4, 0,0,0, 5'd3,64'd7,     0,0);
    add_vec(0,1,1, 5'd1,64'h11,    5'd2,64'h22,    5'd0,5'd0, 0,1,0, 5'd3,64'd7,     0,0);
    add_vec(0,1,1, 5'd1,64'h11,    5'd2,64'h22,    5'd0,5'd0, 1,0,1, 5'd2,64'h22,    0,0);
    add_vec(0,1,1, 5'd1,64'h11,    5'd2,64'h22,    5'd1,5'd1, 0,1,1, 5'd1,64'h11,    1,1);
    add_vec(0,0,1, 5'd0,64'd0,     5'd31,64'hFF,   5'd2,5'd5, 0,1,1, 5'd2,64'h22,    1,0);
    add_vec(0,1,1, 5'd1,64'h11,    5'd2,64'h22,    5'd2,5'd0, 1,0,0, 5'd2,64'h22,    0,0);
    add_vec(1,1,1, 5'd1,64'h11,    5'd2,64'h22,    5'd1,5'd0, 0,0,1, 5'd1,64'h11,    1,0);
    add_vec(1,1,0, 5'd1,64'h11,    5'd0,64'd0,     5'd1,5'd0, 0,0,0, 5'd1,64'h11,    0,0);
    add_vec(0,0,1, 5'd0,64'd0,     5'd5,64'h55,    5'd0,5'd0, 0,1,0, 5'd1,64'h11,    0,0);
    add_vec(0,0,0, 5'd0,64'd0,     5'd0,64'd0,     5'd5,5'd6, 0,0,1, 5'd5,64'h55,    1,0);
    add_vec(0,0,0, 5'd0,64'd0,     5'd0,64'd0,     5'd5,5'd6, 0,0,0, 5'd5,64'h55,    0,0);

    foreach (vecs[i]) begin
      set_in(vecs[i].stall, vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].d0,
             vecs[i].a1, vecs[i].d1, vecs[i].ra, vecs[i].rb);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].eg0, vecs[i].eg1, vecs[i].ew,
                vecs[i].ea, vecs[i].ed, vecs[i].efa, vecs[i].efb);
      @(negedge clk);
    end

    // Stalled request waits, then goes through once the stall lifts
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 0, 5'd9, 64'hAB, 0, 0, 5'd9, 0);
      #1;
      check_all($sformatf("stall%0d", k), 0, 0, 0, 5'd5, 64'h55, 0, 0);
      @(negedge clk);
    end
    set_in(0, 1, 0, 5'd9, 64'hAB, 0, 0, 5'd9, 0);
    #1;
    check_all("unstall", 1, 0, 0, 5'd5, 64'h55, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
    #1;
    check_all("unstall_issue", 0, 0, 1, 5'd9, 64'hAB, 1, 0);
    @(negedge clk);

    // Reset right after an acceptance drops the pending write
    set_in(0, 1, 0, 5'd4, 64'd9, 0, 0, 0, 0);
    #1;
    check("rst_mid gnt0", DW'(gnt0), DW'(1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("rst_mid", 0, 0, 0, 5'd0, 64'd0, 0, 0);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("rst_after", 0, 0, 0, 5'd0, 64'd0, 0, 0);
    @(negedge clk);
    #1;
    check_all("rst_after2", 0, 0, 0, 5'd0, 64'd0, 0, 0);

    // Back-to-back contention from reset: 0,1,0,1 with consecutive writes
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, 1, 5'd1, 64'd1, 5'd2, 64'd2, 0, 0);
      #1;
      check_all($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1, k > 0,
                (k == 0) ? 5'd0 : ((k % 2) == 1 ? 5'd1 : 5'd2),
                (k == 0) ? 64'd0 : ((k % 2) == 1 ? 64'd1 : 64'd2), 0, 0);
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all("rr_tail", 0, 0, 1, 5'd2, 64'd2, 0, 0);
    @(negedge clk);

    // Randomised traffic; each requester holds its request until granted
    do_reset();
    m_last = 1; m_write = 1'b0; m_addr = '0; m_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int            winner;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          eg0, eg1;
      if (!req0 && ($urandom % 3) == 0) begin
        req0 = 1'b1;
        wrAddr0 = (($urandom % 8) == 0) ? AW'(ZR) : AW'($urandom);
        wrData0 = {$urandom, $urandom};
      end
      if (!req1 && ($urandom % 3) == 0) begin
        req1 = 1'b1;
        wrAddr1 = (($urandom % 8) == 0) ? AW'(ZR) : AW'($urandom);
        wrData1 = {$urandom, $urandom};
      end
      stall   = ($urandom % 4) == 0;
      rdAddrA = ($urandom % 2) ? m_addr : AW'($urandom);
      rdAddrB = ($urandom % 2) ? m_addr : AW'($urandom);
      #1;
      winner = -1;
      if (!stall) begin
        if (req0 && req1) winner = 1 - m_last;
        else if (req0)    winner = 0;
        else if (req1)    winner = 1;
      end
      eg0 = (winner == 0);
      eg1 = (winner == 1);
      check_all($sformatf("rand%0d", cyc), eg0, eg1, m_write, m_addr, m_data,
                m_write && (m_addr == rdAddrA), m_write && (m_addr == rdAddrB));
      wa = (winner == 0) ? wrAddr0 : wrAddr1;
      wd = (winner == 0) ? wrData0 : wrData1;
      @(posedge clk);
      if (winner >= 0) begin
        m_last = winner;
        if (wa != AW'(ZR)) begin
          m_write = 1'b1; m_addr = wa; m_data = wd;
        end else begin
          m_write = 1'b0;
        end
      end else begin
        m_write = 1'b0;
      end
      @(negedge clk);
      if (winner == 0) req0 = 1'b0;
      if (winner == 1) req1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 64: write-data width, matching the 32x64 register file.
REQ-002 Parameter ADDR_W, default 5: register address width.
REQ-003 Parameter ZERO_REG, default 31: hard-wired zero register; writes to it are discarded.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port stall  input  1: while high, no request is granted.
REQ-007 Port req0  input  1: requester 0 write request.
REQ-008 Port wrAddr0  input  ADDR_W: requester 0 target register.
REQ-009 Port wrData0  input  DATA_W: requester 0 write data.
REQ-010 Port gnt0  output  1: requester 0 request accepted this cycle.
REQ-011 Ports req1, wrAddr1, wrData1, gnt1 SHALL mirror REQ-007..REQ-010 for requester 1.
REQ-012 Port write  output  1: register-file write enable.
REQ-013 Port wrAddr  output  ADDR_W: register-file write address.
REQ-014 Port wrData  output  DATA_W: register-file write data.
REQ-015 Ports rdAddrA, rdAddrB  input  ADDR_W: register-file read addresses, observed for bypass.
REQ-016 Ports fwdA, fwdB  output  1: read address matches the write issued this cycle.

Function
REQ-017 Handshake: requester holds reqN, wrAddrN, wrDataN stable until gnt pulses; acceptance = reqN & gntN at a rising edge.
REQ-018 gnt0/gnt1 combinational from req, stall and priority state; at most one high per cycle.
REQ-019 stall=1 -> gnt0=gnt1=0; pending requests wait, none lost.
REQ-020 Single requester (stall=0) -> granted same cycle regardless of priority state.
REQ-021 Both requesting -> grant the requester not granted most recently (round-robin).
REQ-022 Priority state (1 bit, last-granted) updates only on a grant.
REQ-023 Accepted request -> next cycle write=1, wrAddr/wrData = captured values, for exactly one cycle; latency 1.
REQ-024 Cycle with no acceptance -> next cycle write=0; wrAddr/wrData hold their previous values.
REQ-025 Accepted request with address ZERO_REG -> gnt pulses normally, write stays 0 next cycle, priority still updates.
REQ-026 Throughput: one write per cycle; back-to-back grants -> write high on consecutive cycles.
REQ-027 fwdA = write & (wrAddr == rdAddrA); fwdB likewise for rdAddrB; combinational.
REQ-028 No buffering beyond the single output register; gnt is the only flow control.

Reset
REQ-029 rst_n low -> immediately write=0, wrAddr=0, wrData=0, gnt0=gnt1=0, fwdA=fwdB=0.
REQ-030 Reset -> priority state = requester 1 last granted, so requester 0 wins the first contention.
REQ-031 Reset between acceptance and issue -> captured write dropped; write stays 0; requester not re-granted automatically.
REQ-032 First grant possible in the first cycle after rst_n deasserts.

Verification
REQ-033 req0=1, wrAddr0=3, wrData0=7 after reset -> gnt0=1 that cycle; next cycle write=1, wrAddr=3, wrData=7; then write=0.
REQ-034 req0 and req1 held high 4 cycles (addr 1 and 2) -> grants 0,1,0,1; write high 4 consecutive cycles, wrAddr 1,2,1,2.
REQ-035 req1=1, wrAddr1=31, wrData1=0xFF -> gnt1=1; next cycle write=0; then contended request -> requester 0 granted.
REQ-036 req0=1 with stall=1 for 3 cycles -> gnt0=0, write=0 throughout; stall drops -> gnt0=1, write next cycle.
REQ-037 Issued write wrAddr=5 with rdAddrA=5, rdAddrB=6 -> fwdA=1, fwdB=0; write=0 -> both 0.
REQ-038 rst_n asserted the cycle after gnt0 (addr 4, data 9) -> write stays 0, wrAddr=0, wrData=0 immediately.
